cpu_trace_buffer: RTL

Captures the per-cycle commit state of the single-cycle CPU (PC, opcode, ALU result, register write-back data) into a FIFO and drains it to a host or bench through a valid/ready read port. It sits beside the CPU on its debug observation bus and consumes the signals the CPU produces each clock. It lets a bench or debug host read back an execution trace at its own pace instead of sampling the CPU live.

---
 rtl/cpu_trace_buffer_if.sv | 27 ++
 rtl/cpu_trace_buffer.sv | 110 +++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer_if.sv
// Debug observation bus between the CPU commit stage and the trace buffer,
// plus the valid/ready drain port toward the host.
interface cpu_trace_buffer_if;
  logic        sample_en;
  logic [31:0] currentAddress;
  logic [5:0]  op;
  logic [31:0] ALU_out;
  logic [31:0] WD;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_op;
  logic [31:0] out_alu;
  logic [31:0] out_wd;
  logic [15:0] out_ts;

  modport master (
    output sample_en, currentAddress, op, ALU_out, WD, out_ready,
    input  out_valid, out_pc, out_op, out_alu, out_wd, out_ts
  );

  modport slave (
    input  sample_en, currentAddress, op, ALU_out, WD, out_ready,
    output out_valid, out_pc, out_op, out_alu, out_wd, out_ts
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Commit-trace FIFO: records CPU commit state while armed, drains through a
// first-word fall-through valid/ready port at the host's pace.
module cpu_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              stop,
  cpu_trace_buffer_if.slave bus,
  output logic [AW:0]       count,
  output logic              capturing,
  output logic [15:0]       dropped
);

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [15:0] ts;
  } rec_t;

  typedef enum logic {IDLE, CAPTURE} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   ts;
  rec_t          mem [DEPTH];
  rec_t          head;
  logic          full, push, pop, drop;

  assign full          = (count == FULL);
  assign bus.out_valid = (count != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign capturing     = (state == CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arm takes priority over everything: a sample on the arm edge is discarded.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (!arm) begin
          push = bus.sample_en && (!full || pop);
          drop = bus.sample_en && full && !pop;
          if (stop) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dropped <= '0;
      ts      <= '0;
    end else if (arm) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dropped <= '0;
      ts      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && dropped != 16'hFFFF) dropped <= dropped + 1'b1;
      if (state == CAPTURE) ts <= ts + 1'b1;
    end
  end

  // Storage carries no reset; stale entries are never visible while count == 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc:  bus.currentAddress,
                       op:  bus.op,
                       alu: bus.ALU_out,
                       wd:  bus.WD,
                       ts:  ts};
    end
  end

  assign head        = mem[rd_ptr];
  assign bus.out_pc  = head.pc;
  assign bus.out_op  = head.op;
  assign bus.out_alu = head.alu;
  assign bus.out_wd  = head.wd;
  assign bus.out_ts  = head.ts;

endmodule
